// File: rtl/pc_pkg.sv
// Shared constants and FSM encoding for the program-counter unit.
package pc_pkg;

  localparam int unsigned PC_W        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [PC_W-1:0] PC_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } pc_state_e;

endpackage

// File: rtl/signed_adder_param.sv
// Two's-complement adder; the sum wraps modulo 2^WIDTH with no overflow flag.
module signed_adder_param #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter: sequential advance, branch/jump/register redirects,
// stall hold and a sticky fault on misaligned register targets.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH        = PC_W,
  parameter logic [WIDTH-1:0] RESET_VECTOR = PC_RESET_VECTOR
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Stall,
  input  logic             Imem_Ready,
  input  logic             Branch_Taken,
  input  logic [WIDTH-1:0] Branch_Offset,
  input  logic             Jump,
  input  logic [25:0]      Jump_Index,
  input  logic             Jump_Reg,
  input  logic [WIDTH-1:0] Reg_Target,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC_Plus4,
  output logic             PC_Valid,
  output logic             Flush,
  output logic             Misaligned
);

  pc_state_e        state_q;
  pc_state_e        state_d;
  logic [WIDTH-1:0] pc_d;
  logic             flush_d;
  logic             mis_d;
  logic [WIDTH-1:0] branch_off_sh;
  logic [WIDTH-1:0] branch_tgt;
  logic [WIDTH-1:0] jump_tgt;
  logic             jr_bad;

  // Sequential next address
  signed_adder_param #(.WIDTH(WIDTH)) u_plus4 (
    .a   (PC),
    .b   (WIDTH'(INSTR_BYTES)),
    .sum (PC_Plus4)
  );

  // Branch target: word offset scaled to bytes, relative to PC+4
  assign branch_off_sh = Branch_Offset << 2;

  signed_adder_param #(.WIDTH(WIDTH)) u_branch (
    .a   (PC_Plus4),
    .b   (branch_off_sh),
    .sum (branch_tgt)
  );

  assign jump_tgt = WIDTH'({PC_Plus4[WIDTH-1 -: 4], Jump_Index, 2'b00});
  assign jr_bad   = Jump_Reg && (Reg_Target[1:0] != 2'b00);
  assign PC_Valid = (state_q == FETCH);

  // Next-state, next-PC and flush/fault decode
  always_comb begin
    state_d = state_q;
    pc_d    = PC;
    flush_d = 1'b0;
    mis_d   = Misaligned;
    unique case (state_q)
      BOOT: begin
        if (jr_bad) begin
          state_d = FAULT;
          mis_d   = 1'b1;
        end else begin
          state_d = FETCH;
        end
      end
      FETCH, HOLD: begin
        if (jr_bad) begin
          state_d = FAULT;
          mis_d   = 1'b1;
        end else if (Jump_Reg) begin
          pc_d    = Reg_Target;
          flush_d = 1'b1;
          state_d = FETCH;
        end else if (Jump) begin
          pc_d    = jump_tgt;
          flush_d = 1'b1;
          state_d = FETCH;
        end else if (Branch_Taken) begin
          pc_d    = branch_tgt;
          flush_d = 1'b1;
          state_d = FETCH;
        end else if (state_q == HOLD) begin
          if (!Stall) state_d = FETCH;
        end else if (Stall) begin
          state_d = HOLD;
        end else if (Imem_Ready) begin
          pc_d = PC_Plus4;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State, PC and status registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= BOOT;
      PC         <= RESET_VECTOR;
      Flush      <= 1'b0;
      Misaligned <= 1'b0;
    end else begin
      state_q    <= state_d;
      PC         <= pc_d;
      Flush      <= flush_d;
      Misaligned <= mis_d;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed scenarios plus randomized traffic
// compared against a behavioural model of the fetch address sequence.
module tb_pc_unit;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Stall = 1'b0;
  logic        Imem_Ready = 1'b1;
  logic        Branch_Taken = 1'b0;
  logic [31:0] Branch_Offset = '0;
  logic        Jump = 1'b0;
  logic [25:0] Jump_Index = '0;
  logic        Jump_Reg = 1'b0;
  logic [31:0] Reg_Target = '0;
  logic [31:0] PC;
  logic [31:0] PC_Plus4;
  logic        PC_Valid;
  logic        Flush;
  logic        Misaligned;

  always #5 Clk = ~Clk;

  pc_unit dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .Stall         (Stall),
    .Imem_Ready    (Imem_Ready),
    .Branch_Taken  (Branch_Taken),
    .Branch_Offset (Branch_Offset),
    .Jump          (Jump),
    .Jump_Index    (Jump_Index),
    .Jump_Reg      (Jump_Reg),
    .Reg_Target    (Reg_Target),
    .PC            (PC),
    .PC_Plus4      (PC_Plus4),
    .PC_Valid      (PC_Valid),
    .Flush         (Flush),
    .Misaligned    (Misaligned)
  );

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        flush;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: where the fetch stream is and what mode it is in
  logic [31:0] m_pc;
  bit          m_boot, m_hold, m_fault, m_flush;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_pc    = 32'h0000_0000;
    m_boot  = 1'b1;
    m_hold  = 1'b0;
    m_fault = 1'b0;
    m_flush = 1'b0;
  endfunction

  function automatic bit model_valid();
    return !m_boot && !m_hold && !m_fault;
  endfunction

  // One rising edge of the model, using the inputs presented before the edge
  function automatic void model_edge();
    logic [31:0] p4;
    bit          jr_bad;
    p4      = m_pc + 32'd4;
    jr_bad  = Jump_Reg && (Reg_Target % 4 != 0);
    m_flush = 1'b0;
    if (m_fault) begin
    end else if (jr_bad) begin
      m_fault = 1'b1;
      m_boot  = 1'b0;
      m_hold  = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (Jump_Reg || Jump || Branch_Taken) begin
      if (Jump_Reg)  m_pc = Reg_Target;
      else if (Jump) m_pc = {p4[31:28], Jump_Index, 2'b00};
      else           m_pc = 32'(p4 + Branch_Offset * 32'd4);
      m_flush = 1'b1;
      m_hold  = 1'b0;
    end else if (m_hold) begin
      m_hold = Stall;
    end else if (Stall) begin
      m_hold = 1'b1;
    end else if (Imem_Ready) begin
      m_pc = p4;
    end
  endfunction

  // Advance one clock; expected outputs after the edge go to the scoreboard
  task automatic step();
    exp_t e;
    @(posedge Clk);
    model_edge();
    e.pc    = m_pc;
    e.valid = model_valid();
    e.flush = m_flush;
    e.mis   = m_fault;
    sb.push_back(e);
    @(negedge Clk);
  endtask

  task automatic set_idle();
    Stall         = 1'b0;
    Imem_Ready    = 1'b1;
    Branch_Taken  = 1'b0;
    Branch_Offset = '0;
    Jump          = 1'b0;
    Jump_Index    = '0;
    Jump_Reg      = 1'b0;
    Reg_Target    = '0;
  endtask

  // Called at a falling edge: assert reset between edges, check the
  // asynchronous effect, release at the next falling edge
  task automatic do_reset();
    #2 Reset_n = 1'b0;
    #1;
    check("rst_async_pc", PC, 32'h0000_0000);
    check("rst_async_valid", 32'(PC_Valid), 32'd0);
    check("rst_async_flush", 32'(Flush), 32'd0);
    check("rst_async_mis", 32'(Misaligned), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
    #1;
    check("boot_pc", PC, 32'h0000_0000);
    check("boot_valid", 32'(PC_Valid), 32'd0);
  endtask

  task automatic jr_to(input logic [31:0] tgt);
    set_idle();
    Jump_Reg   = 1'b1;
    Reg_Target = tgt;
    step();
    set_idle();
  endtask

  // Monitor: compare every post-edge output against the scoreboard head
  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("pc", PC, e.pc);
      check("pc_plus4", PC_Plus4, e.pc + 32'd4);
      check("pc_valid", 32'(PC_Valid), 32'(e.valid));
      check("flush", 32'(Flush), 32'(e.flush));
      check("misaligned", 32'(Misaligned), 32'(e.mis));
    end
  end

  initial begin
    logic [31:0] r;
    set_idle();
    model_reset();
    @(negedge Clk);
    do_reset();

    // Straight-line fetch from reset
    repeat (4) step();

    // Branch backward and forward from 0x100
    jr_to(32'h0000_0100);
    Branch_Taken = 1'b1; Branch_Offset = 32'hFFFF_FFFE;
    step();
    set_idle(); step();
    jr_to(32'h0000_0100);
    Branch_Taken = 1'b1; Branch_Offset = 32'h0000_0003;
    step();
    set_idle(); step();

    // Jump outranks branch
    jr_to(32'h4000_0010);
    Jump = 1'b1; Jump_Index = 26'h10; Branch_Taken = 1'b1; Branch_Offset = 32'd5;
    step();
    set_idle(); step();

    // Stall hold, then register redirect while stalled
    jr_to(32'h0000_0020);
    Stall = 1'b1;
    repeat (3) step();
    Jump_Reg = 1'b1; Reg_Target = 32'h0000_0080;
    step();
    Jump_Reg = 1'b0;
    step();
    Stall = 1'b0;
    repeat (2) step();

    // Redirect while memory is not ready
    Imem_Ready = 1'b0; Jump = 1'b1; Jump_Index = 26'h3FF_FFFF;
    step();
    set_idle(); Imem_Ready = 1'b0; step();

    // Address wrap at the top of memory
    jr_to(32'hFFFF_FFFC);
    repeat (2) step();

    // Misaligned register target faults until reset
    jr_to(32'h0000_0082 - 32'h0);
    Jump_Reg = 1'b1; Reg_Target = 32'h0000_0082;
    step();
    set_idle(); Jump = 1'b1; Branch_Taken = 1'b1;
    repeat (3) step();
    set_idle();
    do_reset();
    repeat (2) step();

    // Reset in the middle of a stall with a pending redirect
    Stall = 1'b1; step();
    Jump = 1'b1; Jump_Index = 26'h123;
    do_reset();
    set_idle();
    repeat (3) step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      Stall        = ($urandom_range(0, 3) == 0);
      Imem_Ready   = ($urandom_range(0, 3) != 0);
      Branch_Taken = ($urandom_range(0, 4) == 0);
      Jump         = ($urandom_range(0, 7) == 0);
      Jump_Reg     = ($urandom_range(0, 9) == 0);
      Jump_Index   = 26'($urandom);
      if ($urandom_range(0, 1) == 0) Branch_Offset = 32'($urandom_range(0, 64)) - 32'd32;
      else                           Branch_Offset = $urandom;
      r = $urandom;
      if ($urandom_range(0, 40) == 0) Reg_Target = {r[31:2], 2'(r[1:0] | 2'b01)};
      else                            Reg_Target = {r[31:2], 2'b00};
      step();
      if ((m_fault && $urandom_range(0, 3) == 0) || (i % 250 == 249)) begin
        do_reset();
      end
    end

    set_idle();
    step();
    #20;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
